// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
// Module   : multiport_register_file
// Purpose  : Parametrised integer register file. It has NUM_RD combinational
//            read ports, a write-to-read bypass and a zeroing sweep after reset.
//            Define REGFILE_SCOREBOARD_EN to build the pending-write scoreboard
//            that drives REG_R_Busy.
// Revision : 1.0 - initial release
// ============================================================================
module multiport_register_file #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*AW-1:0]     REG_R_Addr,
    output logic [NUM_RD*DATA_W-1:0] REG_R_Data,
    output logic [NUM_RD-1:0]        REG_R_Busy,
    input  logic                     REG_W_En,
    input  logic [AW-1:0]            REG_W_Addr,
    input  logic [DATA_W-1:0]        REG_W_Data,
    input  logic                     Issue_En,
    input  logic [AW-1:0]            Issue_RD,
    output logic                     Ready
);

    localparam logic        c_ST_CLEAR = 1'b0;
    localparam logic        c_ST_RUN   = 1'b1;
    localparam logic [AW:0] c_IDX_LAST = (AW+1)'(NUM_REGS - 1);
    localparam logic [AW:0] c_IDX_ONE  = (AW+1)'(1);

    logic              r_state;
    logic              w_state_nxt;
    logic [AW:0]       r_sweep_idx;
    logic [AW:0]       w_sweep_idx_nxt;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_run;
    logic              w_wr;

    assign w_run = (r_state == c_ST_RUN);
    assign w_wr  = REG_W_En & w_run;
    assign Ready = w_run;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_ST_CLEAR;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_idx_nxt = r_sweep_idx;
        if (r_state == c_ST_CLEAR) begin
            w_sweep_idx_nxt = r_sweep_idx + c_IDX_ONE;
            if (r_sweep_idx == c_IDX_LAST) begin
                w_state_nxt = c_ST_RUN;
            end
        end
    end

    // Storage needs no reset: the sweep zeroes it, and reads are masked until RUN.
    always_ff @(posedge CLK) begin
        if (!w_run) begin
            r_regs[r_sweep_idx[AW-1:0]] <= '0;
        end else if (w_wr && (REG_W_Addr != '0)) begin
            r_regs[REG_W_Addr] <= REG_W_Data;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_pending;

    // The set is ordered after the clear, so a new producer supersedes a retiring one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pending <= '0;
        end else if (w_run) begin
            if (REG_W_En) begin
                r_pending[REG_W_Addr] <= 1'b0;
            end
            if (Issue_En && (Issue_RD != '0)) begin
                r_pending[Issue_RD] <= 1'b1;
            end
        end
    end
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{Issue_En, Issue_RD};
`endif

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
            logic [AW-1:0]     w_addr;
            logic              w_nz;
            logic              w_hit;
            logic [DATA_W-1:0] w_data;

            assign w_addr = REG_R_Addr[p*AW +: AW];
            assign w_nz   = (w_addr != '0);
            assign w_hit  = w_wr && (REG_W_Addr == w_addr);
            assign w_data = (!w_run || !w_nz) ? '0 :
                            w_hit             ? REG_W_Data :
                                                r_regs[w_addr];
            assign REG_R_Data[p*DATA_W +: DATA_W] = w_data;
`ifdef REGFILE_SCOREBOARD_EN
            assign REG_R_Busy[p] = w_run & w_nz & r_pending[w_addr] & ~w_hit;
`else
            assign REG_R_Busy[p] = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_register_file
// Purpose  : Self-checking bench for multiport_register_file (32x32, 2 ports).
//            Busy expectations apply only when REGFILE_SCOREBOARD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiport_register_file;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int AW       = 5;
`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_RD*AW-1:0]     reg_r_addr = '0;
    logic [NUM_RD*DATA_W-1:0] reg_r_data;
    logic [NUM_RD-1:0]        reg_r_busy;
    logic                     reg_w_en = 1'b0;
    logic [AW-1:0]            reg_w_addr = '0;
    logic [DATA_W-1:0]        reg_w_data = '0;
    logic                     issue_en = 1'b0;
    logic [AW-1:0]            issue_rd = '0;
    logic                     ready;

    multiport_register_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .REG_R_Addr (reg_r_addr),
        .REG_R_Data (reg_r_data),
        .REG_R_Busy (reg_r_busy),
        .REG_W_En   (reg_w_en),
        .REG_W_Addr (reg_w_addr),
        .REG_W_Data (reg_w_data),
        .Issue_En   (issue_en),
        .Issue_RD   (issue_rd),
        .Ready      (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
    } vec_t;

    typedef struct {
        logic        rdy;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the negedge.
    task automatic step(input string tag, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic iss, input logic [4:0] ird,
                        input logic [4:0] ra0, input logic [4:0] ra1, input logic rdy,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic b0, input logic b1);
        exp_t e;
        reg_w_en   = we;
        reg_w_addr = wa;
        reg_w_data = wd;
        issue_en   = iss;
        issue_rd   = ird;
        reg_r_addr = {ra1, ra0};
        e.rdy = rdy;
        e.d0  = d0;
        e.d1  = d1;
        e.b0  = b0 & SB;
        e.b1  = b1 & SB;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual empty-queue required entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " ready"}, 32'(ready), 32'(e.rdy));
            check({tag, " data0"}, reg_r_data[31:0], e.d0);
            check({tag, " data1"}, reg_r_data[63:32], e.d1);
            check({tag, " busy0"}, 32'(reg_r_busy[0]), 32'(e.b0));
            check({tag, " busy1"}, 32'(reg_r_busy[1]), 32'(e.b1));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic iss, input logic [4:0] ird,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic b0, input logic b1);
        vec_t v;
        v.we = we;   v.wa = wa;   v.wd = wd;   v.iss = iss; v.ird = ird;
        v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0;   v.d1 = d1;   v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    initial begin
        //            we wa  wd            iss ird ra0 ra1 d0            d1            b0 b1
        vecs.push_back(mk(1, 7,  32'hDEADBEEF, 0, 0, 7,  7,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0, 7,  7,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 0,  32'h12345678, 1, 0, 0,  0,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0, 0,  0,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 3, 3,  7,  32'h0,        32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0, 3,  3,  32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0, 3,  0,  32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(1, 3,  32'h00000033, 0, 0, 3,  3,  32'h00000033, 32'h00000033, 0, 0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0, 3,  3,  32'h00000033, 32'h00000033, 0, 0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 9, 9,  3,  32'h0,        32'h00000033, 0, 0));
        vecs.push_back(mk(1, 9,  32'h00000099, 1, 9, 9,  9,  32'h00000099, 32'h00000099, 0, 0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0, 9,  9,  32'h00000099, 32'h00000099, 1, 1));
        vecs.push_back(mk(1, 12, 32'hA5A5A5A5, 0, 0, 12, 9,  32'hA5A5A5A5, 32'h00000099, 0, 1));
        vecs.push_back(mk(1, 20, 32'h00000001, 0, 0, 12, 9,  32'hA5A5A5A5, 32'h00000099, 0, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0, 20, 7,  32'h00000001, 32'hDEADBEEF, 0, 0));

        // Reset state, checked before any clock edge.
        #2;
        check("reset ready", 32'(ready), 32'h0);
        check("reset data", reg_r_data[31:0] | reg_r_data[63:32], 32'h0);
        check("reset busy", 32'(reg_r_busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sweep with writes and issues to register 5 that must be ignored.
        for (int k = 0; k < NUM_REGS; k++) begin
            step($sformatf("sweep%0d", k), 1, 5, 32'hFFFFFFFF, 1, 5, 5, 5, 0, 0, 0, 0, 0);
        end
        step("post-sweep", 0, 0, 0, 0, 0, 5, 5, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iss,
                 vecs[i].ird, vecs[i].ra0, vecs[i].ra1, 1, vecs[i].d0, vecs[i].d1,
                 vecs[i].b0, vecs[i].b1);
        end

        // Mid-run reset: outputs must react before any clock edge.
        reg_w_en   = 1'b0;
        issue_en   = 1'b0;
        reg_r_addr = {5'd9, 5'd9};
        rst = 1'b1;
        #1;
        check("midrst ready", 32'(ready), 32'h0);
        check("midrst busy", 32'(reg_r_busy), 32'h0);
        check("midrst data", reg_r_data[31:0], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            step($sformatf("resweep%0d", k), 0, 0, 0, 0, 0, 12, 9, 0, 0, 0, 0, 0);
        end
        step("post-resweep", 0, 0, 0, 0, 0, 12, 9, 1, 0, 0, 0, 0);
        step("post-resweep x20", 0, 0, 0, 0, 0, 20, 7, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised integer register file for the decode stage, replacing the fixed 32x32, two-read, negedge-write file.
- Adds configurable width, depth and read-port count.
- Writes on the rising edge, with a same-cycle write-to-read bypass.
- Performs a sequential zeroing sweep after reset, so no register ever reads as X.
- Includes an optional pending-write scoreboard that gives the hazard unit a per-read-port busy flag for long-latency producers such as loads.

## Interface
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of registers; a power of two, ≥ 2. AW = $clog2(NUM_REGS).
- NUM_RD, 2, number of read ports, 1..4.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- REG_R_Addr  input  NUM_RD*AW  read addresses; port p uses bits [p*AW +: AW].
- REG_R_Data  output  NUM_RD*DATA_W  read data; port p uses bits [p*DATA_W +: DATA_W]. Combinational.
- REG_R_Busy  output  NUM_RD  port p's register has an outstanding producer. Combinational.
- REG_W_En  input  1  writeback enable.
- REG_W_Addr  input  AW  writeback address.
- REG_W_Data  input  DATA_W  writeback data.
- Issue_En  input  1  an instruction with a tracked destination is issuing this cycle.
- Issue_RD  input  AW  destination register of the issuing instruction.
- Ready  output  1  clear sweep is complete and the file is usable; 0 during reset.

## Operation
- FSM states: CLEAR and RUN.
- RST asserted: the FSM enters CLEAR, the sweep index goes to 0, all pending bits go to 0, and Ready goes to 0.
- CLEAR state:
  - Each rising edge writes 0 to reg[index] and increments the index.
  - When index == NUM_REGS-1 is written, the FSM goes to RUN.
  - REG_W_En and Issue_En are ignored.
  - All REG_R_Data read 0 and all REG_R_Busy read 0.
- RUN state:
  - Ready = 1.
  - On each edge with REG_W_En=1 and REG_W_Addr≠0, reg[REG_W_Addr] ← REG_W_Data.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - Its pending bit is never set.
- Read port p, in RUN:
  - Address 0 returns 0.
  - Otherwise, if REG_W_En=1 and REG_W_Addr == addr, it returns REG_W_Data (bypass).
  - Otherwise it returns reg[addr].
  - All ports are independent; any number of them may name the same register.
- Scoreboard, in RUN:
  - An edge with Issue_En=1 and Issue_RD≠0 sets pending[Issue_RD].
  - An edge with REG_W_En=1 clears pending[REG_W_Addr].
  - If the set and the clear target the same register on the same edge, the set wins: the new producer supersedes the old one.
- REG_R_Busy[p] = pending[addr_p] & ~(REG_W_En & REG_W_Addr == addr_p) & (addr_p≠0). The bypass supplies the data in the cycle the producer writes back.
- Arithmetic: the sweep index is AW+1 bits wide, so it never wraps before the terminal compare. Addresses are unsigned.

## Timing
- Reset values:
  - Ready = 0.
  - REG_R_Data = 0 and REG_R_Busy = 0 on all ports.
  - All pending bits = 0.
- Clear latency: with RST deasserted before edge 1, registers 0..NUM_REGS-1 are cleared on edges 1..NUM_REGS, and Ready = 1 after edge NUM_REGS.
- Write-to-read latency: 0 cycles via the bypass, and the value persists from the following cycle.
- Issue-to-busy latency: 1 cycle. Busy is visible in the cycle after Issue_En.
- Reset asserted mid-sweep or mid-RUN: the sweep restarts from index 0 and all pending bits clear immediately, without waiting for a clock edge.

## Configuration
- REGFILE_SCOREBOARD_EN defined: the pending bits, the Issue_En/Issue_RD logic and REG_R_Busy behave as described above.
- REGFILE_SCOREBOARD_EN undefined:
  - No pending storage is built.
  - Issue_En and Issue_RD are unused.
  - REG_R_Busy is tied to 0.
  - The ports remain present.

## Test plan
- Reset and sweep with NUM_REGS=32:
  - Pulse RST, then hold Issue_En=1 and REG_W_En=1 with REG_W_Addr=5 during the sweep.
  - Required: Ready rises exactly after 32 edges; reg5 reads 0; no Busy flag is set.
- Bypass:
  - In RUN, drive REG_W_En=1, REG_W_Addr=7, REG_W_Data=0xDEADBEEF, and point read ports 0 and 1 at 7 in the same cycle.
  - Required: both ports read 0xDEADBEEF in that cycle and in the next.
- x0:
  - Write 0x12345678 to address 0 and issue with Issue_RD=0.
  - Required: every port reading address 0 returns 0, and its Busy stays 0.
- Scoreboard (macro defined):
  - Issue to Issue_RD=3, then write back to address 3 three cycles later.
  - Required: Busy for address 3 is 1 in cycles +1 and +2, and 0 in cycle +3 (bypass cycle) and after.
- Simultaneous set and clear:
  - With pending[9]=1, issue to 9 and write back to 9 on the same edge.
  - Required: pending[9] stays set, and Busy for address 9 is 1 on the next cycle.
- Mid-run reset:
  - After writing 0xA5A5A5A5 to reg 12, assert RST for 1 cycle.
  - Required: Ready drops immediately and pending clears; after the new sweep, reg12 reads 0.
